// File: rtl/msft_dv_debug_apb_master_pkg.sv
// Shared widths, response bit positions and FSM encoding for the
// debug-port APB master.
package msftDvDebug_jtag2AxiApb_pkg;

  localparam int APB_CMD_WIDTH    = 33;
  localparam int APB_RESP_WIDTH   = 35;

  // apb_cmd_i[32]: auto-increment for setup commands, write for rd/wr commands
  localparam int CMD_FLAG_BIT     = 32;

  localparam int RESP_SLVERR_BIT  = 32;
  localparam int RESP_TIMEOUT_BIT = 33;
  localparam int RESP_BUSY_BIT    = 34;

  localparam logic [31:0] ADDR_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  // Word-aligned post-increment; wraps naturally at 2^32.
  function automatic logic [31:0] next_addr(input logic [31:0] addr);
    return addr + ADDR_STEP;
  endfunction

endpackage

// File: rtl/msft_dv_debug_apb_master.sv
// Debug APB master: executes one address-setup or one read/write command at
// a time, drives a single APB transfer, and reports the result with a
// one-cycle ack and a held response word.
module msft_dv_debug_apb_master
  import msftDvDebug_jtag2AxiApb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [1:0]                apb_req_i,
  output logic                      apb_ack_o,
  input  logic [APB_CMD_WIDTH-1:0]  apb_cmd_i,
  output logic [APB_RESP_WIDTH-1:0] apb_resp_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [31:0]               paddr_o,
  output logic [31:0]               pwdata_o,
  output logic [3:0]                pstrb_o,
  output logic [2:0]                pprot_o,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  input  logic [31:0]               prdata_i
);

  // Last ACCESS wait count before the transfer is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  apb_state_e  r_state;
  apb_state_e  w_state_nxt;
  logic        w_xfer_end;
  logic        w_timeout_hit;

  logic [31:0] r_addr;
  logic        r_autoinc;
  logic        r_pwrite;
  logic [31:0] r_pwdata;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_slverr;
  logic        r_timeout;
  logic        r_busy;
  logic        r_psel;
  logic        r_penable;
  logic        r_ack;
  logic [3:0]  r_pstrb;
  logic [2:0]  r_pprot;

  // Next-state decode; the setup command wins when both request bits are set.
  always_comb begin
    w_state_nxt   = r_state;
    w_xfer_end    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (apb_req_i[1]) begin
          w_state_nxt = ST_DONE;
        end else if (apb_req_i[0]) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          w_state_nxt = ST_DONE;
          w_xfer_end  = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_DONE;
          w_xfer_end    = 1'b1;
          w_timeout_hit = 1'b1;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // APB control and ack flops, decoded from the next state so they are
  // registered yet aligned with the state they belong to.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_pstrb   <= 4'h0;
      r_pprot   <= 3'b000;
    end else begin
      r_psel    <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      r_penable <= (w_state_nxt == ST_ACCESS);
      r_ack     <= (w_state_nxt == ST_DONE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_pstrb   <= 4'hF;
      r_pprot   <= PPROT_VAL;
    end
  end

  // Command latching, wait counter, address increment and response capture.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_addr    <= 32'h0;
      r_autoinc <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= 32'h0;
      r_cnt     <= 16'h0;
      r_rdata   <= 32'h0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (apb_req_i[1]) begin
            r_addr    <= apb_cmd_i[31:0];
            r_autoinc <= apb_cmd_i[CMD_FLAG_BIT];
          end else if (apb_req_i[0]) begin
            r_pwrite  <= apb_cmd_i[CMD_FLAG_BIT];
            r_pwdata  <= apb_cmd_i[31:0];
          end
        end
        ST_SETUP: begin
          r_cnt <= 16'h0;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            if (!r_pwrite) begin
              r_rdata <= prdata_i;
            end
            r_slverr  <= pslverr_i;
            r_timeout <= 1'b0;
          end else if (w_timeout_hit) begin
            r_slverr  <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
          if (w_xfer_end && r_autoinc) begin
            r_addr <= next_addr(r_addr);
          end
        end
        ST_DONE: begin
          r_cnt <= 16'h0;
        end
        default: begin
          r_cnt <= 16'h0;
        end
      endcase
    end
  end

  assign apb_ack_o                    = r_ack;
  assign apb_resp_o[31:0]             = r_rdata;
  assign apb_resp_o[RESP_SLVERR_BIT]  = r_slverr;
  assign apb_resp_o[RESP_TIMEOUT_BIT] = r_timeout;
  assign apb_resp_o[RESP_BUSY_BIT]    = r_busy;
  assign psel_o                       = r_psel;
  assign penable_o                    = r_penable;
  assign pwrite_o                     = r_pwrite;
  assign paddr_o                      = r_addr;
  assign pwdata_o                     = r_pwdata;
  assign pstrb_o                      = r_pstrb;
  assign pprot_o                      = r_pprot;

endmodule

// File: tb/tb_msft_dv_debug_apb_master.sv
// Self-checking bench for the debug APB master: directed vector table,
// reset-in-ACCESS sequence, then random commands against a command-level model.
module tb_msft_dv_debug_apb_master;

  localparam int         TMO  = 16;
  localparam logic [2:0] PROT = 3'b101;

  logic        clk_i;
  logic        rstn_i;
  logic [1:0]  apb_req_i;
  logic        apb_ack_o;
  logic [32:0] apb_cmd_i;
  logic [34:0] apb_resp_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic        pready_i;
  logic        pslverr_i;
  logic [31:0] prdata_i;

  int n_vec;
  int n_mis;

  // command-level reference model state
  logic [31:0] m_addr;
  logic        m_ainc;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_to;

  typedef struct {
    logic [1:0]  req;
    logic [32:0] cmd;
    int          waits;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          sel;
    int          acc;
    logic [31:0] paddr;
    logic [34:0] resp;
  } vec_t;

  vec_t tbl[13];

  msft_dv_debug_apb_master #(
    .TIMEOUT_CYCLES(TMO),
    .PPROT_VAL     (PROT)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .apb_req_i (apb_req_i),
    .apb_ack_o (apb_ack_o),
    .apb_cmd_i (apb_cmd_i),
    .apb_resp_o(apb_resp_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .pstrb_o   (pstrb_o),
    .pprot_o   (pprot_o),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i),
    .prdata_i  (prdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 32'h0; m_ainc = 1'b0; m_rdata = 32'h0; m_err = 1'b0; m_to = 1'b0;
  endtask

  // Predicts one command from the rules: latency, bus cycles, address, response.
  task automatic model_step(input logic [1:0] req, input logic [32:0] cmd, input int waits,
                            input logic [31:0] rd, input logic err,
                            output int lat, output int sel, output int acc,
                            output logic [31:0] paddr, output logic [34:0] resp);
    paddr = m_addr;
    if (req[1]) begin
      m_addr = cmd[31:0];
      m_ainc = cmd[32];
      lat = 1; sel = 0; acc = 0;
    end else begin
      acc = (waits >= TMO) ? TMO : waits + 1;
      sel = acc + 1;
      lat = sel + 1;
      if (waits >= TMO) begin
        m_to = 1'b1; m_err = 1'b0;
      end else begin
        m_to = 1'b0; m_err = err;
        if (!cmd[32]) m_rdata = rd;
      end
      if (m_ainc) m_addr = m_addr + 32'd4;
    end
    resp = {1'b0, m_to, m_err, m_rdata};
  endtask

  // Issues one command at a negedge, acts as the APB slave, checks per-cycle
  // protocol, and reports what was observed.
  task automatic run_cmd(input logic [1:0] req, input logic [32:0] cmd, input int waits,
                         input logic [31:0] rd, input logic err, input logic [33:0] hold,
                         output int lat, output int sel, output int acc,
                         output logic [31:0] paddr, output logic [34:0] resp);
    bit done;
    lat = -1; sel = 0; acc = 0; paddr = 32'h0; resp = 35'h0; done = 1'b0;
    apb_req_i = req; apb_cmd_i = cmd; pready_i = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk_i);
      if (lat < 0) begin
        if (apb_ack_o) begin
          lat = n;
          chk("ack_psel", 64'(psel_o), 64'd0);
          chk("ack_penable", 64'(penable_o), 64'd0);
          chk("ack_busy", 64'(apb_resp_o[34]), 64'd1);
          apb_req_i = 2'b00; pready_i = 1'b0;
        end else begin
          chk("busy", 64'(apb_resp_o[34]), 64'd1);
          chk("resp_hold", 64'(apb_resp_o[33:0]), 64'(hold));
          if (psel_o) begin
            if (sel == 0) paddr = paddr_o;
            else chk("paddr_stable", 64'(paddr_o), 64'(paddr));
            chk("penable", 64'(penable_o), 64'(sel != 0));
            chk("pwrite", 64'(pwrite_o), 64'(cmd[32]));
            chk("pwdata", 64'(pwdata_o), 64'(cmd[31:0]));
            chk("pstrb", 64'(pstrb_o), 64'hF);
            chk("pprot", 64'(pprot_o), 64'(PROT));
            sel++;
            if (penable_o) begin
              pready_i  = (acc == waits);
              prdata_i  = (acc == waits) ? rd : $urandom();
              pslverr_i = (acc == waits) ? err : 1'($urandom_range(0, 1));
              acc++;
            end else begin
              pready_i = 1'b0;
            end
          end else begin
            pready_i = 1'b0;
          end
        end
      end else begin
        resp = apb_resp_o;
        chk("ack_once", 64'(apb_ack_o), 64'd0);
        chk("idle_psel", 64'(psel_o), 64'd0);
        done = 1'b1;
      end
    end
    apb_req_i = 2'b00; pready_i = 1'b0;
  endtask

  task automatic compare(input string nm, input int lat, input int sel, input int acc,
                         input logic [31:0] pa, input logic [34:0] rs,
                         input int e_lat, input int e_sel, input int e_acc,
                         input logic [31:0] e_pa, input logic [34:0] e_rs);
    chk({nm, "_latency"}, 64'(lat), 64'(e_lat));
    chk({nm, "_psel_cycles"}, 64'(sel), 64'(e_sel));
    chk({nm, "_access_cycles"}, 64'(acc), 64'(e_acc));
    if (e_sel != 0) chk({nm, "_paddr"}, 64'(pa), 64'(e_pa));
    chk({nm, "_resp"}, 64'(rs), 64'(e_rs));
  endtask

  initial begin
    int lat, sel, acc, e_lat, e_sel, e_acc;
    logic [31:0] pa, e_pa;
    logic [34:0] rs, e_rs;
    logic [33:0] hold;
    logic [1:0] rq;
    logic [32:0] cm;
    int wt;
    n_vec = 0; n_mis = 0;

    //          req    cmd                    waits rd            err lat sel acc paddr          resp
    tbl[0]  = '{2'b10, {1'b1, 32'h4000_0000}, 0,  32'h0,        0,  1,  0,  0,  32'h0,         35'h0};
    tbl[1]  = '{2'b01, {1'b1, 32'h0000_0011}, 0,  32'h0,        0,  3,  2,  1,  32'h4000_0000, 35'h0};
    tbl[2]  = '{2'b01, {1'b1, 32'h0000_0022}, 0,  32'h0,        0,  3,  2,  1,  32'h4000_0004, 35'h0};
    tbl[3]  = '{2'b01, {1'b1, 32'h0000_0033}, 0,  32'h0,        0,  3,  2,  1,  32'h4000_0008, 35'h0};
    tbl[4]  = '{2'b10, {1'b0, 32'h0000_1000}, 0,  32'h0,        0,  1,  0,  0,  32'h0,         35'h0};
    tbl[5]  = '{2'b01, {1'b0, 32'h0000_0000}, 5,  32'hDEADBEEF, 0,  8,  7,  6,  32'h0000_1000, 35'h0_DEADBEEF};
    tbl[6]  = '{2'b01, {1'b1, 32'h0000_CAFE}, 2,  32'h0,        1,  5,  4,  3,  32'h0000_1000, 35'h1_DEADBEEF};
    tbl[7]  = '{2'b10, {1'b1, 32'h0000_2000}, 0,  32'h0,        0,  1,  0,  0,  32'h0,         35'h1_DEADBEEF};
    tbl[8]  = '{2'b01, {1'b0, 32'h0000_0000}, 20, 32'h0,        0,  18, 17, 16, 32'h0000_2000, 35'h2_DEADBEEF};
    tbl[9]  = '{2'b01, {1'b0, 32'h0000_0000}, 0,  32'h12345678, 0,  3,  2,  1,  32'h0000_2004, 35'h0_12345678};
    tbl[10] = '{2'b11, {1'b1, 32'hFFFF_FFFC}, 0,  32'h0,        0,  1,  0,  0,  32'h0,         35'h0_12345678};
    tbl[11] = '{2'b01, {1'b1, 32'h0000_A5A5}, 1,  32'h0,        0,  4,  3,  2,  32'hFFFF_FFFC, 35'h0_12345678};
    tbl[12] = '{2'b01, {1'b0, 32'h0000_0000}, 0,  32'h0BADF00D, 0,  3,  2,  1,  32'h0000_0000, 35'h0_0BADF00D};

    rstn_i = 1'b0; apb_req_i = 2'b00; apb_cmd_i = 33'h0;
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0;
    model_reset();

    // reset values
    repeat (2) @(negedge clk_i);
    chk("rst_ack", 64'(apb_ack_o), 64'd0);
    chk("rst_resp", 64'(apb_resp_o), 64'd0);
    chk("rst_psel", 64'(psel_o), 64'd0);
    chk("rst_penable", 64'(penable_o), 64'd0);
    chk("rst_pwrite", 64'(pwrite_o), 64'd0);
    chk("rst_paddr", 64'(paddr_o), 64'd0);
    chk("rst_pwdata", 64'(pwdata_o), 64'd0);
    chk("rst_pstrb", 64'(pstrb_o), 64'd0);
    chk("rst_pprot", 64'(pprot_o), 64'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // directed table
    for (int i = 0; i < 13; i++) begin
      hold = {m_to, m_err, m_rdata};
      model_step(tbl[i].req, tbl[i].cmd, tbl[i].waits, tbl[i].rd, tbl[i].err,
                 e_lat, e_sel, e_acc, e_pa, e_rs);
      run_cmd(tbl[i].req, tbl[i].cmd, tbl[i].waits, tbl[i].rd, tbl[i].err, hold,
              lat, sel, acc, pa, rs);
      compare($sformatf("tbl%0d", i), lat, sel, acc, pa, rs,
              tbl[i].lat, tbl[i].sel, tbl[i].acc, tbl[i].paddr, tbl[i].resp);
    end

    // reset asserted in the middle of ACCESS
    apb_req_i = 2'b01; apb_cmd_i = {1'b0, 32'h0}; pready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("mid_access_psel", 64'(psel_o), 64'd1);
    chk("mid_access_penable", 64'(penable_o), 64'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_psel", 64'(psel_o), 64'd0);
    chk("arst_penable", 64'(penable_o), 64'd0);
    chk("arst_ack", 64'(apb_ack_o), 64'd0);
    chk("arst_resp", 64'(apb_resp_o), 64'd0);
    apb_req_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("arst_no_ack", 64'(apb_ack_o), 64'd0);
    end
    rstn_i = 1'b1;
    model_reset();

    // random commands against the model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       rq = 2'b10;
        1:       rq = 2'b11;
        default: rq = 2'b01;
      endcase
      cm = {1'($urandom_range(0, 1)), $urandom()};
      if (rq[1] && $urandom_range(0, 2) == 0) cm[31:0] = 32'hFFFF_FFF8;
      wt = ($urandom_range(0, 7) == 0) ? TMO + 1 : int'($urandom_range(0, 4));
      hold = {m_to, m_err, m_rdata};
      model_step(rq, cm, wt, 32'($urandom()), 1'b0, e_lat, e_sel, e_acc, e_pa, e_rs);
      // re-run model inputs consistently: use the same rd/err the model saw
      run_cmd(rq, cm, wt, m_rdata, m_err, hold, lat, sel, acc, pa, rs);
      compare($sformatf("rnd%0d", i), lat, sel, acc, pa, rs, e_lat, e_sel, e_acc, e_pa, e_rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/msft_dv_debug_apb_master.md
MSFT_DV_DEBUG_APB_MASTER -- requirements
Module: msftDvDebug_apbMaster

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, ACCESS-phase wait limit in clk_i cycles before abort (range 2..65535).
REQ-002 Parameter PPROT_VAL, default 3'b000, constant driven on pprot_o.
REQ-003 clk_i  input  1  single clock; all logic SHALL be on posedge clk_i.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 apb_req_i  input  2  [1]=address-setup command, [0]=read/write command; level, held until ack.
REQ-006 apb_ack_o  output  1  one-cycle pulse, command complete.
REQ-007 apb_cmd_i  input  APB_CMD_WIDTH(33)  [31:0] address or wdata, [32] auto-increment (setup) or write (rd/wr).
REQ-008 apb_resp_o  output  APB_RESP_WIDTH(35)  [31:0] rdata, [32] slverr, [33] timeout, [34] busy.
REQ-009 psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-010 paddr_o, pwdata_o  output  32 each; pstrb_o output 4; pprot_o output 3.
REQ-011 pready_i, pslverr_i  input  1 each; prdata_i input 32.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, ACCESS, DONE.
REQ-013 IDLE, apb_req_i[1]=1: load addr_q<=cmd[31:0], autoinc_q<=cmd[32], go DONE; no APB transfer.
REQ-014 IDLE, apb_req_i==2'b01: latch pwrite<=cmd[32], pwdata<=cmd[31:0], go SETUP.
REQ-015 apb_req_i==2'b11 SHALL be handled as setup command only (bit 1 priority).
REQ-016 SETUP: psel_o=1, penable_o=0, paddr_o=addr_q; next cycle ACCESS unconditionally.
REQ-017 ACCESS: psel_o=1, penable_o=1; on pready_i=1 capture prdata_i (reads only; writes keep previous rdata), slverr<=pslverr_i, timeout<=0, go DONE.
REQ-018 ACCESS: timeout counter starts at 0 on entry, increments each cycle pready_i=0; on reaching TIMEOUT_CYCLES-1 with pready_i=0, deassert psel/penable next cycle, timeout<=1, slverr<=0, go DONE.
REQ-019 After completed or timed-out transfer with autoinc_q=1, addr_q SHALL increment by 4 mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-020 DONE: apb_ack_o=1 exactly one cycle, go IDLE; req_i SHALL be ignored in DONE.
REQ-021 Minimum latency: setup command req->ack 1 cycle; rd/wr with zero-wait slave req->ack 3 cycles.
REQ-022 apb_resp_o SHALL be registered and stable from DONE until the next command's DONE; resp[34]=1 whenever state!=IDLE.
REQ-023 pstrb_o SHALL be 4'hF; pprot_o SHALL be PPROT_VAL; paddr_o/pwdata_o/pwrite_o SHALL be stable SETUP through ACCESS.
REQ-024 psel_o/penable_o SHALL be 0 in IDLE and DONE.

Reset
REQ-025 On rstn_i=0: state IDLE, all outputs 0 (apb_resp_o 35'h0), addr_q=0, autoinc_q=0, counter=0.
REQ-026 Reset mid-transfer SHALL drop psel_o/penable_o immediately (asynchronously) with no ack issued.

Structure
REQ-027 APB_CMD_WIDTH, APB_RESP_WIDTH, response bit-index constants and FSM state enum SHALL live in msftDvDebug_jtag2AxiApb_pkg.
REQ-028 Single flat module; no sub-module.

Verification
REQ-029 Setup cmd 0x4000_0000 autoinc=1, then 3 writes 0x11/0x22/0x33 zero-wait -> paddr 0x4000_0000/04/08, ack each 3 cycles after req.
REQ-030 Read at 0x1000 with slave inserting 5 wait states, prdata 0xDEADBEEF -> resp=0x0_DEADBEEF, ack 8 cycles after req.
REQ-031 Write with pslverr_i=1 on pready -> resp[32]=1, resp[33]=0, ack pulse one cycle.
REQ-032 TIMEOUT_CYCLES=16, pready_i held 0 -> psel low after 16 ACCESS cycles, resp[33]=1, ack issued, address incremented if autoinc.
REQ-033 Autoinc from 0xFFFF_FFFC -> second transfer at 0x0000_0000; req=2'b11 -> no psel, ack in 1 cycle.
REQ-034 rstn_i low during ACCESS -> psel/penable 0 same cycle, no ack, resp 0.
